// File: rtl/pipeline_hazard_ctrl.sv
// Hazard interlock and branch-flush controller for the 5-stage SimpleRisc pipeline.
// Define FORWARDING_EN for bypassed operation: only load-use stalls, plus fwd_a_sel/fwd_b_sel outputs.
module pipeline_hazard_ctrl #(
    parameter int MAX_STALL = 8,
    parameter int CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [31:0]      of_instr,
    input  logic             of_valid,
    input  logic [3:0]       ex_rd,
    input  logic             ex_iswb,
    input  logic             ex_isld,
    input  logic             ex_valid,
    input  logic [3:0]       ma_rd,
    input  logic             ma_iswb,
    input  logic             ma_valid,
    input  logic             ex_branch_taken,
    output logic             pc_stall,
    output logic             if_of_stall,
    output logic             if_of_flush,
    output logic             of_ex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`ifdef FORWARDING_EN
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
`endif
    output logic             hang_err
);
    localparam int RUN_W = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,  OP_DIV = 5'd3;
    localparam logic [4:0] OP_MOD = 5'd4,  OP_CMP = 5'd5,  OP_AND = 5'd6,  OP_OR  = 5'd7;
    localparam logic [4:0] OP_NOT = 5'd8,  OP_MOV = 5'd9,  OP_LSL = 5'd10, OP_LSR = 5'd11;
    localparam logic [4:0] OP_ASR = 5'd12, OP_LD  = 5'd14, OP_ST  = 5'd15, OP_RET = 5'd20;

    typedef enum logic {ST_RUN, ST_STALL} state_e;

    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hang_err_q, hang_err_d;

    logic [4:0] opcode;
    logic       imm;
    logic [3:0] rd_f, rs1_f, rs2_f;
    logic       use_a, use_b;
    logic [3:0] src_a, src_b;
    logic       ex_wr, ma_wr, raw, stall_req;
    logic       unused_bits;

    assign opcode      = of_instr[31:27];
    assign imm         = of_instr[26];
    assign rd_f        = of_instr[25:22];
    assign rs1_f       = of_instr[21:18];
    assign rs2_f       = of_instr[17:14];
    assign unused_bits = ^{of_instr[13:0], ex_isld};

    // Operand A is rs1 (r15 for ret); operand B is rs2, or the store-data register rd for st.
    always_comb begin
        use_a = 1'b0;
        use_b = 1'b0;
        src_a = rs1_f;
        src_b = rs2_f;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_CMP,
            OP_AND, OP_OR, OP_LSL, OP_LSR, OP_ASR: begin
                use_a = 1'b1;
                use_b = ~imm;
            end
            OP_NOT, OP_MOV: use_b = ~imm;
            OP_LD:          use_a = 1'b1;
            OP_ST: begin
                use_a = 1'b1;
                use_b = 1'b1;
                src_b = rd_f;
            end
            OP_RET: begin
                use_a = 1'b1;
                src_a = 4'd15;
            end
            default: ;
        endcase
    end

    assign ex_wr = ex_valid & ex_iswb;
    assign ma_wr = ma_valid & ma_iswb;

`ifdef FORWARDING_EN
    // Bypass covers every producer except a load whose data is not yet out of memory.
    assign raw = of_valid & ex_valid & ex_isld &
                 ((use_a & (src_a == ex_rd)) | (use_b & (src_b == ex_rd)));

    always_comb begin
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        if (!Reset && of_valid) begin
            if (use_a && ex_wr && (src_a == ex_rd))      fwd_a_sel = 2'd1;
            else if (use_a && ma_wr && (src_a == ma_rd)) fwd_a_sel = 2'd2;
            if (use_b && ex_wr && (src_b == ex_rd))      fwd_b_sel = 2'd1;
            else if (use_b && ma_wr && (src_b == ma_rd)) fwd_b_sel = 2'd2;
        end
    end
`else
    assign raw = of_valid &
                 ((use_a & ((ex_wr & (src_a == ex_rd)) | (ma_wr & (src_a == ma_rd)))) |
                  (use_b & ((ex_wr & (src_b == ex_rd)) | (ma_wr & (src_b == ma_rd)))));
`endif

    assign stall_req = raw & ~ex_branch_taken;

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (stall_req)  state_d = ST_STALL;
            ST_STALL: if (!stall_req) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // A taken branch squashes the hazarding instruction, so it overrides the interlock.
    always_comb begin
        pc_stall     = 1'b0;
        if_of_stall  = 1'b0;
        if_of_flush  = 1'b0;
        of_ex_bubble = 1'b0;
        if (!Reset) begin
            if (ex_branch_taken) begin
                if_of_flush  = 1'b1;
                of_ex_bubble = 1'b1;
            end else if (raw) begin
                pc_stall     = 1'b1;
                if_of_stall  = 1'b1;
                of_ex_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        run_cnt_d = '0;
        if (state_d == ST_STALL)
            run_cnt_d = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + 1'b1;
        hang_err_d = hang_err_q | (run_cnt_d == RUN_MAX);

        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;

        flush_cnt_d = flush_cnt_q;
        if (ex_branch_taken && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            run_cnt_q   <= '0;
            hang_err_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            run_cnt_q   <= run_cnt_d;
            hang_err_q  <= hang_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign hang_err  = hang_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, corner sequences and random traffic
// against a register-mask model; a second instance with narrow counters exercises saturation.
module tb_pipeline_hazard_ctrl;
    localparam int MAX_STALL = 8;
    localparam int CNT_W     = 16;
    localparam int SMALL_W   = 4;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_CMP = 5'd5, OP_NOT = 5'd8, OP_MOV = 5'd9;
    localparam logic [4:0] OP_NOP = 5'd13, OP_LD = 5'd14, OP_ST = 5'd15, OP_BEQ = 5'd16;
    localparam logic [4:0] OP_B = 5'd18, OP_CALL = 5'd19, OP_RET = 5'd20;

    logic               Clk = 1'b0;
    logic               Reset;
    logic [31:0]        of_instr;
    logic               of_valid;
    logic [3:0]         ex_rd;
    logic               ex_iswb, ex_isld, ex_valid;
    logic [3:0]         ma_rd;
    logic               ma_iswb, ma_valid;
    logic               ex_branch_taken;
    logic               pc_stall, if_of_stall, if_of_flush, of_ex_bubble, hang_err;
    logic [CNT_W-1:0]   stall_cnt, flush_cnt;
    logic               s_pc_stall, s_if_of_stall, s_if_of_flush, s_of_ex_bubble, s_hang_err;
    logic [SMALL_W-1:0] s_stall_cnt, s_flush_cnt;
`ifdef FORWARDING_EN
    logic [1:0]         fwd_a_sel, fwd_b_sel, s_fwd_a_sel, s_fwd_b_sel;
`endif

    int tests = 0;
    int fails = 0;

    int m_run   = 0;
    bit m_hang  = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 Clk = ~Clk;

    pipeline_hazard_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .of_instr(of_instr), .of_valid(of_valid),
        .ex_rd(ex_rd), .ex_iswb(ex_iswb), .ex_isld(ex_isld), .ex_valid(ex_valid),
        .ma_rd(ma_rd), .ma_iswb(ma_iswb), .ma_valid(ma_valid),
        .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc_stall), .if_of_stall(if_of_stall), .if_of_flush(if_of_flush),
        .of_ex_bubble(of_ex_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`ifdef FORWARDING_EN
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
`endif
        .hang_err(hang_err)
    );

    pipeline_hazard_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(SMALL_W)) dut_small (
        .Clk(Clk), .Reset(Reset), .of_instr(of_instr), .of_valid(of_valid),
        .ex_rd(ex_rd), .ex_iswb(ex_iswb), .ex_isld(ex_isld), .ex_valid(ex_valid),
        .ma_rd(ma_rd), .ma_iswb(ma_iswb), .ma_valid(ma_valid),
        .ex_branch_taken(ex_branch_taken),
        .pc_stall(s_pc_stall), .if_of_stall(s_if_of_stall), .if_of_flush(s_if_of_flush),
        .of_ex_bubble(s_of_ex_bubble), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
`ifdef FORWARDING_EN
        .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
`endif
        .hang_err(s_hang_err)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        of_v;
        logic [3:0]  ex_rd_v;
        logic        ex_wb, ex_ld, ex_v;
        logic [3:0]  ma_rd_v;
        logic        ma_wb, ma_v;
        logic        br;
        logic        stall_full, stall_fwd;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] enc(input logic [4:0] op, input logic i,
                                        input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, i, rd, rs1, rs2, 14'd0};
    endfunction

    function automatic vec_t mk(input string name, input logic [31:0] instr, input logic of_v,
                                input logic [3:0] erd, input logic ewb, input logic eld, input logic ev,
                                input logic [3:0] mrd, input logic mwb, input logic mv,
                                input logic br, input logic s_full, input logic s_fwd);
        vec_t v;
        v.name = name; v.instr = instr; v.of_v = of_v;
        v.ex_rd_v = erd; v.ex_wb = ewb; v.ex_ld = eld; v.ex_v = ev;
        v.ma_rd_v = mrd; v.ma_wb = mwb; v.ma_v = mv; v.br = br;
        v.stall_full = s_full; v.stall_fwd = s_fwd;
        return v;
    endfunction

    function automatic bit is_alu(input logic [4:0] op);
        return (op <= 5'd7) || (op >= 5'd10 && op <= 5'd12);
    endfunction

    // Set of architectural registers the OF instruction reads, as a 16-bit mask.
    function automatic logic [15:0] read_mask(input logic [31:0] ins);
        logic [4:0]  op;
        logic [15:0] m1, m2;
        op = ins[31:27];
        m1 = 16'd1 << ins[21:18];
        m2 = ins[26] ? 16'd0 : (16'd1 << ins[17:14]);
        if (is_alu(op))                   return m1 | m2;
        if (op == OP_NOT || op == OP_MOV) return m2;
        if (op == OP_LD)                  return m1;
        if (op == OP_ST)                  return m1 | (16'd1 << ins[25:22]);
        if (op == OP_RET)                 return 16'h8000;
        return 16'd0;
    endfunction

    function automatic logic [1:0] fwd_expect(input logic [31:0] ins, input logic second);
        logic [4:0]  op;
        logic [15:0] m, exm, mam;
        op = ins[31:27];
        if (!second)
            m = (op == OP_RET) ? 16'h8000 :
                ((is_alu(op) || op == OP_LD || op == OP_ST) ? (16'd1 << ins[21:18]) : 16'd0);
        else
            m = (op == OP_ST) ? (16'd1 << ins[25:22]) :
                (((is_alu(op) || op == OP_NOT || op == OP_MOV) && !ins[26]) ? (16'd1 << ins[17:14]) : 16'd0);
        exm = (ex_valid && ex_iswb) ? (16'd1 << ex_rd) : 16'd0;
        mam = (ma_valid && ma_iswb) ? (16'd1 << ma_rd) : 16'd0;
        if (|(m & exm)) return 2'd1;
        if (|(m & mam)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [3:0] rreg();
        return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        of_instr = v.instr;  of_valid = v.of_v;
        ex_rd = v.ex_rd_v;   ex_iswb = v.ex_wb;  ex_isld = v.ex_ld;  ex_valid = v.ex_v;
        ma_rd = v.ma_rd_v;   ma_iswb = v.ma_wb;  ma_valid = v.ma_v;
        ex_branch_taken = v.br;
    endtask

    // One clock: check every output at the falling edge, then advance the model at the rising edge.
    // t_stall/t_flush >= 0 additionally compare against hand-derived constants.
    task automatic check_output(input string tag, input int t_stall, input int t_flush);
        logic [15:0] wmask;
        logic        raw, e_stall, e_flush;
`ifdef FORWARDING_EN
        logic [1:0]  e_fa, e_fb;
`endif
        @(negedge Clk);
`ifdef FORWARDING_EN
        wmask = (ex_valid && ex_isld) ? (16'd1 << ex_rd) : 16'd0;
`else
        wmask = ((ex_valid && ex_iswb) ? (16'd1 << ex_rd) : 16'd0) |
                ((ma_valid && ma_iswb) ? (16'd1 << ma_rd) : 16'd0);
`endif
        raw     = of_valid && (|(read_mask(of_instr) & wmask));
        e_flush = !Reset && ex_branch_taken;
        e_stall = !Reset && !ex_branch_taken && raw;

        compare({tag, ".pc_stall"},     pc_stall,     e_stall);
        compare({tag, ".if_of_stall"},  if_of_stall,  e_stall);
        compare({tag, ".if_of_flush"},  if_of_flush,  e_flush);
        compare({tag, ".of_ex_bubble"}, of_ex_bubble, e_stall | e_flush);
        compare({tag, ".stall_cnt"},    stall_cnt,    (m_stall > 65535) ? 65535 : m_stall);
        compare({tag, ".flush_cnt"},    flush_cnt,    (m_flush > 65535) ? 65535 : m_flush);
        compare({tag, ".hang_err"},     hang_err,     m_hang);
        compare({tag, ".s_pc_stall"},   s_pc_stall,   e_stall);
        compare({tag, ".s_stall_cnt"},  s_stall_cnt,  (m_stall > 15) ? 15 : m_stall);
        compare({tag, ".s_flush_cnt"},  s_flush_cnt,  (m_flush > 15) ? 15 : m_flush);
        compare({tag, ".s_hang_err"},   s_hang_err,   m_hang);
`ifdef FORWARDING_EN
        e_fa = (Reset || !of_valid) ? 2'd0 : fwd_expect(of_instr, 1'b0);
        e_fb = (Reset || !of_valid) ? 2'd0 : fwd_expect(of_instr, 1'b1);
        compare({tag, ".fwd_a_sel"},   fwd_a_sel,   e_fa);
        compare({tag, ".fwd_b_sel"},   fwd_b_sel,   e_fb);
        compare({tag, ".s_fwd_a_sel"}, s_fwd_a_sel, e_fa);
`endif
        if (t_stall >= 0) compare({tag, ".tbl_stall"}, pc_stall,    t_stall);
        if (t_flush >= 0) compare({tag, ".tbl_flush"}, if_of_flush, t_flush);

        @(posedge Clk);
        if (Reset) begin
            m_run = 0; m_hang = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (e_stall) m_stall++;
            if (e_flush) m_flush++;
            m_run = e_stall ? m_run + 1 : 0;
            if (m_run >= MAX_STALL) m_hang = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        check_output("reset", 0, 0);
        Reset = 1'b0;
    endtask

    task automatic idle_inputs();
        of_instr = enc(OP_NOP, 1'b0, 4'd0, 4'd0, 4'd0);
        of_valid = 1'b0; ex_rd = 4'd0; ex_iswb = 1'b0; ex_isld = 1'b0; ex_valid = 1'b0;
        ma_rd = 4'd0; ma_iswb = 1'b0; ma_valid = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic load_use_hazard();
        of_instr = enc(OP_LD, 1'b1, 4'd5, 4'd7, 4'd0); of_valid = 1'b1;
        ex_rd = 4'd7; ex_iswb = 1'b1; ex_isld = 1'b1; ex_valid = 1'b1;
        ma_valid = 1'b0; ex_branch_taken = 1'b0;
    endtask

    initial begin
        // Reset held with a live hazard and branch: controls must stay low.
        Reset = 1'b1;
        load_use_hazard();
        ex_branch_taken = 1'b1;
        @(posedge Clk); #1;
        check_output("reset_hold", 0, 0);
        ex_branch_taken = 1'b0;
        check_output("reset_hold2", 0, 0);
        Reset = 1'b0;

        vecs.push_back(mk("alu_rs2_ex",     enc(OP_ADD,1'b0,4'd4,4'd1,4'd2), 1, 4'd2,1,0,1, 4'd0,0,0, 0, 1,0));
        vecs.push_back(mk("ex_not_wb",      enc(OP_ADD,1'b0,4'd4,4'd1,4'd2), 1, 4'd2,0,0,1, 4'd0,0,0, 0, 0,0));
        vecs.push_back(mk("imm_rs2_unused", enc(OP_ADD,1'b1,4'd4,4'd1,4'd2), 1, 4'd2,1,1,1, 4'd0,0,0, 0, 0,0));
        vecs.push_back(mk("mov_rs2_ma",     enc(OP_MOV,1'b0,4'd4,4'd6,4'd2), 1, 4'd6,1,1,1, 4'd2,1,1, 0, 1,0));
        vecs.push_back(mk("mov_imm",        enc(OP_MOV,1'b1,4'd4,4'd6,4'd2), 1, 4'd6,1,1,1, 4'd2,1,1, 0, 0,0));
        vecs.push_back(mk("not_rs1_unused", enc(OP_NOT,1'b0,4'd4,4'd3,4'd5), 1, 4'd3,1,1,1, 4'd0,0,0, 0, 0,0));
        vecs.push_back(mk("ld_use",         enc(OP_LD, 1'b1,4'd5,4'd7,4'd0), 1, 4'd7,1,1,1, 4'd0,0,0, 0, 1,1));
        vecs.push_back(mk("st_rd_src",      enc(OP_ST, 1'b1,4'd3,4'd1,4'd0), 1, 4'd3,1,1,1, 4'd0,0,0, 0, 1,1));
        vecs.push_back(mk("ret_ma_call",    enc(OP_RET,1'b0,4'd0,4'd0,4'd0), 1, 4'd0,0,0,0, 4'd15,1,1, 0, 1,0));
        vecs.push_back(mk("ret_ex_ld",      enc(OP_RET,1'b0,4'd0,4'd0,4'd0), 1, 4'd15,1,1,1, 4'd0,0,0, 0, 1,1));
        vecs.push_back(mk("b_fields",       enc(OP_B,  1'b0,4'd2,4'd2,4'd2), 1, 4'd2,1,1,1, 4'd2,1,1, 0, 0,0));
        vecs.push_back(mk("call_fields",    enc(OP_CALL,1'b0,4'd2,4'd2,4'd2),1, 4'd2,1,1,1, 4'd2,1,1, 0, 0,0));
        vecs.push_back(mk("beq_fields",     enc(OP_BEQ,1'b0,4'd2,4'd2,4'd2), 1, 4'd2,1,1,1, 4'd2,1,1, 0, 0,0));
        vecs.push_back(mk("nop_fields",     enc(OP_NOP,1'b0,4'd2,4'd2,4'd2), 1, 4'd2,1,1,1, 4'd2,1,1, 0, 0,0));
        vecs.push_back(mk("cmp_rs2",        enc(OP_CMP,1'b0,4'd0,4'd1,4'd9), 1, 4'd9,1,0,1, 4'd0,0,0, 0, 1,0));
        vecs.push_back(mk("of_bubble",      enc(OP_ADD,1'b0,4'd4,4'd1,4'd2), 0, 4'd1,1,1,1, 4'd2,1,1, 0, 0,0));
        vecs.push_back(mk("ex_invalid",     enc(OP_ADD,1'b0,4'd4,4'd1,4'd2), 1, 4'd1,1,1,0, 4'd0,0,0, 0, 0,0));
        vecs.push_back(mk("ma_invalid",     enc(OP_ADD,1'b0,4'd4,4'd1,4'd2), 1, 4'd0,0,0,0, 4'd1,1,0, 0, 0,0));
        vecs.push_back(mk("branch_over_raw",enc(OP_ADD,1'b0,4'd4,4'd1,4'd2), 1, 4'd1,1,1,1, 4'd0,0,0, 1, 0,0));
        vecs.push_back(mk("undef_op",       enc(5'd25, 1'b0,4'd1,4'd1,4'd1), 1, 4'd1,1,1,1, 4'd1,1,1, 0, 0,0));
        vecs.push_back(mk("r0_dep",         enc(OP_SUB,1'b0,4'd4,4'd0,4'd5), 1, 4'd8,0,0,0, 4'd0,1,1, 0, 1,0));

        foreach (vecs[k]) begin
            apply_stimulus(vecs[k]);
            check_output(vecs[k].name, FWD ? int'(vecs[k].stall_fwd) : int'(vecs[k].stall_full),
                         int'(vecs[k].br));
        end

        // Producer in EX, then MA, then RW while sub r4,r3,r5 waits in OF.
        idle_inputs();
        do_reset();
        of_instr = enc(OP_SUB, 1'b0, 4'd4, 4'd3, 4'd5); of_valid = 1'b1;
        ex_rd = 4'd3; ex_iswb = 1'b1; ex_valid = 1'b1;
        check_output("raw_in_ex", FWD ? 0 : 1, 0);
        ex_valid = 1'b0; ma_rd = 4'd3; ma_iswb = 1'b1; ma_valid = 1'b1;
        check_output("raw_in_ma", FWD ? 0 : 1, 0);
        ma_valid = 1'b0;
        check_output("raw_in_rw", 0, 0);
        compare("stall_cnt_after_raw", stall_cnt, FWD ? 0 : 2);

        // ret waiting on call's r15 write in MA.
        idle_inputs();
        do_reset();
        of_instr = enc(OP_RET, 1'b0, 4'd0, 4'd0, 4'd0); of_valid = 1'b1;
        ma_rd = 4'd15; ma_iswb = 1'b1; ma_valid = 1'b1;
        check_output("ret_call", FWD ? 0 : 1, 0);
        ma_valid = 1'b0;
        check_output("ret_clear", 0, 0);

        // Branch taken during a hazard, then the hazard alone.
        idle_inputs();
        do_reset();
        load_use_hazard();
        ex_branch_taken = 1'b1;
        check_output("br_raw", 0, 1);
        compare("flush_cnt_after_br", flush_cnt, 1);
        ex_branch_taken = 1'b0;
        check_output("raw_after_br", 1, 0);

        // Stall watchdog: trips after MAX_STALL consecutive stall cycles and is sticky.
        idle_inputs();
        do_reset();
        load_use_hazard();
        for (int c = 0; c < MAX_STALL - 1; c++) check_output("hang_build", 1, 0);
        compare("hang_before_limit", hang_err, 0);
        check_output("hang_last", 1, 0);
        compare("hang_at_limit", hang_err, 1);
        ex_valid = 1'b0;
        for (int c = 0; c < 3; c++) check_output("hang_sticky", 0, 0);
        compare("hang_sticky_after_clear", hang_err, 1);
        do_reset();
        compare("hang_after_reset", hang_err, 0);

        // Reset landing on the third cycle of a stall.
        load_use_hazard();
        check_output("mid_stall1", 1, 0);
        check_output("mid_stall2", 1, 0);
        Reset = 1'b1;
        check_output("mid_stall_rst", 0, 0);
        compare("mid_rst_stall_cnt", stall_cnt, 0);
        compare("mid_rst_flush_cnt", flush_cnt, 0);
        Reset = 1'b0;
        check_output("after_mid_rst", 1, 0);

        // Counter saturation, visible on the narrow instance.
        idle_inputs();
        do_reset();
        load_use_hazard();
        for (int c = 0; c < 20; c++) check_output("sat_stall", 1, 0);
        compare("s_stall_cnt_sat", s_stall_cnt, 15);
        compare("stall_cnt_20", stall_cnt, 20);
        ex_branch_taken = 1'b1;
        for (int c = 0; c < 20; c++) check_output("sat_flush", 0, 1);
        compare("s_flush_cnt_sat", s_flush_cnt, 15);
        compare("flush_cnt_20", flush_cnt, 20);

`ifdef FORWARDING_EN
        idle_inputs();
        do_reset();
        of_instr = enc(OP_SUB, 1'b0, 4'd4, 4'd3, 4'd3); of_valid = 1'b1;
        ex_rd = 4'd3; ex_iswb = 1'b1; ex_valid = 1'b1;
        ma_rd = 4'd3; ma_iswb = 1'b1; ma_valid = 1'b1;
        @(negedge Clk);
        compare("fwd_ex_prio_a", fwd_a_sel, 1);
        compare("fwd_ex_prio_b", fwd_b_sel, 1);
        compare("fwd_no_stall", pc_stall, 0);
        @(posedge Clk); #1;
        ex_valid = 1'b0;
        @(negedge Clk);
        compare("fwd_ma_a", fwd_a_sel, 2);
        @(posedge Clk); #1;
        idle_inputs();
        do_reset();
        load_use_hazard();
        check_output("fwd_load_use", 1, 0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            Reset           = ($urandom_range(0, 49) == 0);
            of_instr        = enc(5'($urandom_range(0, 23)), 1'($urandom_range(0, 1)), rreg(), rreg(), rreg());
            of_valid        = ($urandom_range(0, 7) != 0);
            ex_rd           = rreg();
            ex_iswb         = 1'($urandom_range(0, 1));
            ex_isld         = 1'($urandom_range(0, 1));
            ex_valid        = ($urandom_range(0, 3) != 0);
            ma_rd           = rreg();
            ma_iswb         = 1'($urandom_range(0, 1));
            ma_valid        = ($urandom_range(0, 3) != 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            check_output("rand", -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Interlock and flush controller for the 5-stage SimpleRisc pipeline (IF, OF, EX, MA, RW). It decodes the instruction in OF and the destination registers of the instructions in EX and MA, and detects RAW hazards. It also sequences stalls, bubbles and branch flushes into the IF_OF, OF_EX and PC registers, and keeps stall/flush statistics plus a stall watchdog.

Parameters:
MAX_STALL, 8, stall-run length (cycles) at which hang_err is raised
CNT_W, 16, width of the saturating performance counters

Ports:
Clk  input  1  pipeline clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
of_instr  input  32  instruction currently in IF_OF register
of_valid  input  1  OF slot holds a real instruction (not bubble)
ex_rd  input  4  destination register of instruction in OF_EX
ex_iswb  input  1  EX instruction writes register file
ex_isld  input  1  EX instruction is ld
ex_valid  input  1  EX slot valid
ma_rd  input  4  destination register in EX_MA
ma_iswb  input  1  MA instruction writes register file
ma_valid  input  1  MA slot valid
ex_branch_taken  input  1  branch unit in EX redirects PC this cycle
pc_stall  output  1  hold PC
if_of_stall  output  1  hold IF_OF register
if_of_flush  output  1  load nop into IF_OF
of_ex_bubble  output  1  load nop into OF_EX
stall_cnt  output  CNT_W  saturating count of stall cycles
flush_cnt  output  CNT_W  saturating count of taken-branch flushes
hang_err  output  1  sticky watchdog flag

Behaviour:
- Field decode of of_instr: opcode [31:27], I [26], rd [25:22], rs1 [21:18], rs2 [17:14].
- Source use: ALU ops other than mov/not read rs1, and read rs2 when I=0. cmp follows the same rule. mov/not read rs2 only when I=0. ld reads rs1. st reads rs1 and rd. ret reads r15. nop, b, beq, bgt and call read nothing.
- A writer is stage X with X_valid & X_iswb. Its destination is the supplied X_rd; call supplies 15.
- RW-stage writers never cause a hazard, because the register file writes before the OF read.
- raw = of_valid & (any used source == ex_rd for a valid EX writer, or == ma_rd for a valid MA writer).
- Outputs are combinational from inputs and state; all state is registered.
- Priority, highest first:
  - ex_branch_taken: if_of_flush=1, of_ex_bubble=1, pc_stall=0, if_of_stall=0. Overrides any stall.
  - raw: pc_stall=1, if_of_stall=1, of_ex_bubble=1.
  - Otherwise all control outputs are 0.
- State machine:
  - RUN: enter STALL on a raw cycle without a branch.
  - STALL: stay while raw. Return to RUN when raw clears or a branch is taken.
- Stall-run counter: increments each STALL cycle and clears on entry to RUN. When it reaches MAX_STALL, hang_err is set and stays set until Reset.
- stall_cnt increments on every cycle with pc_stall=1. flush_cnt increments on every cycle with ex_branch_taken=1. Both saturate at all-ones.
- Reset: state=RUN, run counter=0, stall_cnt=0, flush_cnt=0, hang_err=0. Control outputs read 0 during Reset regardless of inputs.
- Reset asserted mid-stall: state returns to RUN the next edge and counters clear. Reset has priority over every other event.

Optional Feature:
FORWARDING_EN
- Defined: EX-to-OF and MA-to-OF forwarding is assumed to exist, so only load-use stalls. raw = used source matching ex_rd with ex_valid & ex_isld.
- Defined: add outputs fwd_a_sel[1:0] and fwd_b_sel[1:0] (0=regfile, 1=EX, 2=MA). EX takes priority when both match.
- Undefined: full interlock as described above; the fwd outputs are absent.

Test Plan:
- add r3,r1,r2 in EX (ex_rd=3, iswb) with sub r4,r3,r5 in OF → pc_stall, if_of_stall and of_ex_bubble = 1 for 2 cycles while the writer moves EX→MA; 0 once it reaches RW; stall_cnt=2.
- ret in OF with call in MA (ma_rd=15) → stall 1 cycle; st r3,4[r1] with ex_rd=3 → stall (rd used as source).
- ex_branch_taken=1 while raw=1 → if_of_flush=1, of_ex_bubble=1, pc_stall=0; flush_cnt=1; state RUN next cycle.
- MAX_STALL=8, hazard held constant 8 cycles → hang_err=1 on the 8th; stays 1 after hazard clears; cleared only by Reset.
- Reset asserted on cycle 3 of a stall → next cycle all outputs 0 and counters 0; also check stall_cnt saturation at 0xFFFF with CNT_W=16.
- FORWARDING_EN: add in EX writing r3, consumer in OF → no stall, fwd_a_sel=1; ld in EX writing r3 → 1-cycle stall.
